matmul_accel: RTL and testbench
===============================

# matmul_accel

Bus-attached, parameterised integer matrix-multiply accelerator computing C = A × B with A of size M×K, B of size K×N and C of size M×N. It sits as a slave on the UDM debug bus (MemSplit32 signal set) beside the LED/SW CSRs and test memory. Unlike a combinational multiplier array, it runs a sequential multiply-accumulate (MAC) engine: software loads operands, writes START, polls STATUS or waits for the interrupt, then reads results.

## Interface
- BASE_ADDR, 32'h20000000, window base; the window is 0x400 bytes.
- M, 2, rows of A and C; range 1..16.
- K, 4, columns of A and rows of B; range 1..16.
- N, 2, columns of B and C; range 1..16.
- clk_gen  in  1  system clock.
- srst  in  1  synchronous, active-high reset.
- bus_req_i  in  1  bus request.
- bus_we_i  in  1  1 = write, 0 = read.
- bus_addr_bi  in  32  byte address, word aligned.
- bus_be_bi  in  4  byte enables; ignored, all writes are full-word.
- bus_wdata_bi  in  32  write data.
- bus_ack_o  out  1  request accept.
- bus_resp_o  out  1  read response strobe.
- bus_rdata_bo  out  32  read data, valid only when bus_resp_o = 1.
- irq_o  out  1  one-cycle pulse at run completion.

## Operation
- Register map, as offsets from BASE_ADDR:
  - 0x000 CTRL, write-only. Bit0 = START. Reads return 0.
  - 0x004 STATUS. Bit0 = BUSY (read-only). Bit1 = DONE, sticky, cleared by writing 1 to bit1.
  - 0x008 CYCLES, read-only. Number of RUN cycles in the last completed run.
  - 0x100 + 4·(i·K+k): A[i][k], read/write.
  - 0x200 + 4·(k·N+j): B[k][j], read/write.
  - 0x300 + 4·(i·N+j): C[i][j], read-only.
- Decode rules:
  - Addresses inside the window but outside any mapped range: reads return 0 with a response, writes are ignored.
  - Addresses outside the window: no response, no side effects.
- FSM states: IDLE, RUN, FIN.
  - IDLE → RUN on a START write. Clears DONE, sets i = j = k = 0, acc = 0, cycle count = 0.
  - RUN, every cycle: acc_next = acc + A[i][k]·B[k][j], then k advances.
    - When k = K−1: write C[i][j] = acc_next, reset acc to 0, reset k to 0, advance j; on j wrap, advance i.
    - The cycle that writes C[M−1][N−1] moves the FSM to FIN.
  - FIN → IDLE after one cycle. In FIN: DONE = 1, CYCLES latched, irq_o = 1.
- Arithmetic:
  - Operands are 32-bit two's complement.
  - Each product is truncated to its low 32 bits and accumulated modulo 2^32.
  - No saturation and no overflow flag.
- While BUSY:
  - Writes to A, B and CTRL are ignored.
  - Writes to STATUS bit1 are ignored.
  - Reads are always served. A C entry returns its old value until that entry is written in this run.
- After srst:
  - A, B and C are all 0.
  - State is IDLE; BUSY = DONE = 0; CYCLES = 0.
  - bus_resp_o = 0, bus_rdata_bo = 0, irq_o = 0.

## Timing
- bus_ack_o = bus_req_i, combinational; every request is accepted in its request cycle.
- Reads: bus_resp_o and bus_rdata_bo are registered and appear exactly 1 cycle after the accepted read; resp is a 1-cycle pulse.
- Back-to-back reads give back-to-back responses, one per cycle, in order.
- Writes produce no response. Write data is visible to a read issued the next cycle.
- START write accepted in cycle t:
  - BUSY reads 1 for a read issued at t+1.
  - RUN occupies cycles t+1 .. t+M·N·K.
  - FIN and irq_o occur in cycle t+M·N·K+1; BUSY = 0 from t+M·N·K+2.
  - Default parameters give 16 RUN cycles and CYCLES = 16.
- A read of STATUS issued in FIN returns BUSY = 1, DONE = 1.
- A START write in the same cycle as a STATUS DONE-clear write: START wins, so DONE ends 0 and a run begins.
- srst asserted mid-run aborts the run. Everything returns to reset values on the next edge; no irq_o is generated.

## Test plan
- Reset check: after srst, read STATUS, CYCLES, A[0][0] and C[1][1] → each returns 0 with resp exactly 1 cycle after req.
- Identity run: A = [[1,2,3,4],[5,6,7,8]], B = K×N with B[k][j] = (k==j).
  - Write START → irq_o in cycle t+17.
  - C = [[1,2],[5,6]], STATUS = 0x2, CYCLES = 16.
- Signed and wrap: A all 0xFFFFFFFF (−1), B all 0x80000000.
  - Each product is 0x80000000; 4 products accumulate modulo 2^32.
  - C entries = 0x00000000.
- Busy protection:
  - Mid-run: write A[0][0] = 99 and write START → both ignored.
  - Result equals the undisturbed run; exactly one irq_o pulse.
- Reset mid-run: assert srst at cycle t+5 → BUSY = 0, C = 0, irq_o never pulses.
- Decode:
  - Read BASE+0x3F0 → resp with 0.
  - Read BASE+0x400 → no resp.
  - Write STATUS = 0x2 after a run → DONE reads 0.

Source files
------------

// File: rtl/matmul_accel.sv
// matmul_accel: bus-mapped sequential MAC engine computing C = A x B (modulo 2^32).
module matmul_accel #(
  parameter logic [31:0] BASE_ADDR = 32'h20000000,
  parameter int M = 2,
  parameter int K = 4,
  parameter int N = 2
) (
  input  logic        clk_gen,
  input  logic        srst,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        irq_o
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam int AW = M * K > 1 ? $clog2(M * K) : 1;
  localparam int BW = K * N > 1 ? $clog2(K * N) : 1;
  localparam int CW = M * N > 1 ? $clog2(M * N) : 1;
  logic [31:0] a [M*K];
  logic [31:0] b [K*N];
  logic [31:0] c [M*N];
  state_t state;
  logic [4:0] i, j, k;
  logic [31:0] acc, cnt, cycles, acc_next, rdata_n;
  logic done, hit, wr, rd, busy, a_ok, b_ok, c_ok, last_i, last_j, last_k;
  logic [1:0] rg;
  logic [5:0] w;
  logic [AW-1:0] ai, ma;
  logic [BW-1:0] bi, mb;
  logic [CW-1:0] ci, mc;
  logic unused;
  assign unused = ^{bus_be_bi, bus_addr_bi[1:0]};
  assign bus_ack_o = bus_req_i;
  always_comb begin
    hit = bus_req_i && bus_addr_bi[31:10] == BASE_ADDR[31:10];
    wr = hit && bus_we_i;
    rd = hit && !bus_we_i;
    rg = bus_addr_bi[9:8];
    w = bus_addr_bi[7:2];
    busy = state != IDLE;
    a_ok = rg == 2'd1 && {26'd0, w} < 32'(M * K);
    b_ok = rg == 2'd2 && {26'd0, w} < 32'(K * N);
    c_ok = rg == 2'd3 && {26'd0, w} < 32'(M * N);
    ai = AW'(w);
    bi = BW'(w);
    ci = CW'(w);
    ma = AW'(i * K + k);
    mb = BW'(k * N + j);
    mc = CW'(i * N + j);
    last_i = i == 5'(M - 1);
    last_j = j == 5'(N - 1);
    last_k = k == 5'(K - 1);
    acc_next = acc + a[ma] * b[mb];
    rdata_n = rg == 2'd0 ? (w == 6'd1 ? {30'd0, done, busy} : w == 6'd2 ? cycles : 32'd0)
            : a_ok ? a[ai] : b_ok ? b[bi] : c_ok ? c[ci] : 32'd0;
  end
  always_ff @(posedge clk_gen) begin
    if (srst) begin
      for (int n = 0; n < M * K; n++) a[n] <= '0;
      for (int n = 0; n < K * N; n++) b[n] <= '0;
      for (int n = 0; n < M * N; n++) c[n] <= '0;
      state <= IDLE;
      {i, j, k} <= '0;
      acc <= '0;
      cnt <= '0;
      cycles <= '0;
      done <= 1'b0;
      irq_o <= 1'b0;
      bus_resp_o <= 1'b0;
      bus_rdata_bo <= '0;
    end else begin
      bus_resp_o <= rd;
      if (rd) bus_rdata_bo <= rdata_n;
      irq_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wr && a_ok) a[ai] <= bus_wdata_bi;
          if (wr && b_ok) b[bi] <= bus_wdata_bi;
          if (wr && rg == 2'd0 && w == 6'd1 && bus_wdata_bi[1]) done <= 1'b0;
          // START overrides any DONE handling: it always clears DONE
          if (wr && rg == 2'd0 && w == 6'd0 && bus_wdata_bi[0]) begin
            state <= RUN;
            done <= 1'b0;
            {i, j, k} <= '0;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + 32'd1;
          k <= last_k ? 5'd0 : k + 5'd1;
          acc <= last_k ? 32'd0 : acc_next;
          if (last_k) begin
            c[mc] <= acc_next;
            j <= last_j ? 5'd0 : j + 5'd1;
            if (last_j) i <= i + 5'd1;
            if (last_j && last_i) begin
              state <= FIN;
              done <= 1'b1;
              irq_o <= 1'b1;
              cycles <= cnt + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_accel.sv
// tb_matmul_accel: directed register-level checks of matmul_accel with a read-response scoreboard.
module tb_matmul_accel;
  localparam logic [31:0] B0 = 32'h20000000;
  logic clk_gen = 1'b0, srst = 1'b1;
  logic bus_req_i = 1'b0, bus_we_i = 1'b0;
  logic [31:0] bus_addr_bi = '0, bus_wdata_bi = '0;
  logic [3:0] bus_be_bi = 4'hF;
  logic bus_ack_o, bus_resp_o, irq_o;
  logic [31:0] bus_rdata_bo;
  int compared = 0, mismatched = 0, cyc = 0, irq_cnt = 0;
  logic [31:0] q_exp[$];
  int q_cyc[$];
  string q_nm[$];

  matmul_accel dut (
    .clk_gen(clk_gen), .srst(srst), .bus_req_i(bus_req_i), .bus_we_i(bus_we_i),
    .bus_addr_bi(bus_addr_bi), .bus_be_bi(bus_be_bi), .bus_wdata_bi(bus_wdata_bi),
    .bus_ack_o(bus_ack_o), .bus_resp_o(bus_resp_o), .bus_rdata_bo(bus_rdata_bo), .irq_o(irq_o)
  );

  always #5 clk_gen = ~clk_gen;
  always @(posedge clk_gen) cyc <= cyc + 1;

  always @(negedge clk_gen) begin
    if (irq_o) irq_cnt++;
    if (bus_resp_o) begin
      compared++;
      if (q_exp.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_resp: data=%h at cycle %0d with nothing outstanding", bus_rdata_bo, cyc);
      end else begin
        logic [31:0] e;
        int c;
        string nm;
        e = q_exp.pop_front();
        c = q_cyc.pop_front();
        nm = q_nm.pop_front();
        if (bus_rdata_bo !== e || cyc != c + 1) begin
          mismatched++;
          $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", nm, bus_rdata_bo, cyc, e, c + 1);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_bi = B0 + off; bus_wdata_bi = d;
    @(posedge clk_gen); #1;
    bus_req_i = 1'b0; bus_we_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm, input bit expect_resp = 1'b1);
    if (expect_resp) begin
      q_exp.push_back(exp); q_cyc.push_back(cyc); q_nm.push_back(nm);
    end
    bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = addr;
    @(posedge clk_gen); #1;
    bus_req_i = 1'b0;
  endtask

  task automatic wait_irq(input int t, input string nm);
    int n;
    n = 0;
    @(negedge clk_gen);
    while (!irq_o && n < 60) begin
      @(negedge clk_gen);
      n++;
    end
    if (!irq_o) chk({nm, "_irq_timeout"}, 32'd0, 32'd1);
    else chk({nm, "_irq_cycle"}, 32'(cyc), 32'(t + 17));
  endtask

  task automatic load(input logic [31:0] av [8], input logic [31:0] bv [8]);
    for (int n = 0; n < 8; n++) wr(32'h100 + 4 * n, av[n]);
    for (int n = 0; n < 8; n++) wr(32'h200 + 4 * n, bv[n]);
  endtask

  initial begin
    int t, ic;
    logic [31:0] av [8];
    logic [31:0] bv [8];
    repeat (3) @(posedge clk_gen);
    #1 srst = 1'b0;
    rd(B0 + 32'h004, 32'h0, "rst_status");
    rd(B0 + 32'h008, 32'h0, "rst_cycles");
    rd(B0 + 32'h100, 32'h0, "rst_a00");
    rd(B0 + 32'h30C, 32'h0, "rst_c11");
    chk("rst_irq", {31'd0, irq_o}, 32'd0);

    av = '{1, 2, 3, 4, 5, 6, 7, 8};
    bv = '{1, 0, 0, 1, 0, 0, 0, 0};
    load(av, bv);
    rd(B0 + 32'h11C, 32'd8, "a13_readback");
    t = cyc;
    wr(32'h000, 32'h1);
    rd(B0 + 32'h004, 32'h1, "id_busy");
    wait_irq(t, "id");
    rd(B0 + 32'h004, 32'h3, "fin_status");
    rd(B0 + 32'h300, 32'd1, "id_c00");
    rd(B0 + 32'h304, 32'd2, "id_c01");
    rd(B0 + 32'h308, 32'd5, "id_c10");
    rd(B0 + 32'h30C, 32'd6, "id_c11");
    rd(B0 + 32'h004, 32'h2, "id_status");
    rd(B0 + 32'h008, 32'd16, "id_cycles");

    rd(B0 + 32'h3F0, 32'h0, "unmapped_c_region");
    rd(B0 + 32'h00C, 32'h0, "unmapped_reg");
    rd(B0 + 32'h000, 32'h0, "ctrl_reads_zero");
    rd(B0 + 32'h400, 32'h0, "outside_window", 1'b0);
    repeat (3) @(posedge clk_gen);
    #1;
    wr(32'h004, 32'h2);
    rd(B0 + 32'h004, 32'h0, "done_cleared");

    av = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    bv = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
           32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
    load(av, bv);
    t = cyc;
    wr(32'h000, 32'h1);
    wait_irq(t, "wrap");
    for (int n = 0; n < 4; n++) rd(B0 + 32'h300 + 4 * n, 32'h0, "wrap_c");
    rd(B0 + 32'h008, 32'd16, "wrap_cycles");

    av = '{1, 2, 3, 4, 5, 6, 7, 8};
    bv = '{1, 2, 3, 4, 5, 6, 7, 8};
    load(av, bv);
    ic = irq_cnt;
    t = cyc;
    wr(32'h000, 32'h1);
    wr(32'h100, 32'd99);
    wr(32'h000, 32'h1);
    rd(B0 + 32'h30C, 32'h0, "busy_old_c11");
    rd(B0 + 32'h100, 32'd1, "busy_a00_kept");
    wait_irq(t, "busy");
    repeat (30) @(posedge clk_gen);
    #1;
    chk("busy_irq_count", 32'(irq_cnt - ic), 32'd1);
    rd(B0 + 32'h300, 32'd50, "mac_c00");
    rd(B0 + 32'h304, 32'd60, "mac_c01");
    rd(B0 + 32'h308, 32'd114, "mac_c10");
    rd(B0 + 32'h30C, 32'd140, "mac_c11");
    rd(B0 + 32'h100, 32'd1, "busy_a00_after");

    ic = irq_cnt;
    t = cyc;
    wr(32'h000, 32'h1);
    repeat (4) @(posedge clk_gen);
    #1 srst = 1'b1;
    @(posedge clk_gen);
    #1 srst = 1'b0;
    rd(B0 + 32'h004, 32'h0, "abort_status");
    rd(B0 + 32'h300, 32'h0, "abort_c00");
    rd(B0 + 32'h30C, 32'h0, "abort_c11");
    rd(B0 + 32'h104, 32'h0, "abort_a01");
    rd(B0 + 32'h008, 32'h0, "abort_cycles");
    repeat (30) @(posedge clk_gen);
    #1;
    chk("abort_no_irq", 32'(irq_cnt - ic), 32'd0);
    chk("queue_drained", 32'(q_exp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
